// File: rtl/packet_traffic_gen.sv
// packet_traffic_gen: packet-level traffic source for NoC router ports.
// Emits head/body/tail packets with selectable destination pattern, honours
// on/off backpressure, and provides start/stop/budget run control with an
// inter-packet gap and per-run flit/packet counters.
module packet_traffic_gen #(
  parameter int FLIT_SIZE = 32,
  parameter int PKT_LEN   = 4,
  parameter int NUM_DEST  = 4,
  parameter int GAP_W     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [1:0]           i_mode,
  input  logic [GAP_W-1:0]     i_gap,
  input  logic [CNT_W-1:0]     i_num_pkts,
  input  logic                 i_on_off,
  output logic [FLIT_SIZE-1:0] o_flit,
  output logic                 o_transmit,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_pkt_cnt,
  output logic [CNT_W-1:0]     o_flit_cnt
);
  localparam int ADDR_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int IDX_W  = $clog2(PKT_LEN);
  localparam int PLD_W  = FLIT_SIZE - 2;
  localparam int HLW    = FLIT_SIZE - 2 - ADDR_W;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(PKT_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_DEST = ADDR_W'(NUM_DEST - 1);
  localparam logic [15:0]       LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]       budget_q, budget_d;
  logic [CNT_W-1:0]       pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]       flit_cnt_q, flit_cnt_d;
  logic [IDX_W-1:0]       flit_idx_q, flit_idx_d;
  logic [ADDR_W-1:0]      dest_ptr_q, dest_ptr_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   stop_seen_q, stop_seen_d;
  logic [FLIT_SIZE-1:0]   flit_q, flit_d;
  logic                   transmit_q, transmit_d;
  logic                   done_q, done_d;

  logic [ADDR_W-1:0]      dest;
  logic [PLD_W-1:0]       payload;
  logic [CNT_W-1:0]       pkt_cnt_inc;
  logic                   is_tail;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shift-right form
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [FLIT_SIZE-1:0] head_flit(input logic [ADDR_W-1:0] d,
                                                     input logic [CNT_W-1:0] pkts);
    return {2'b01, d, HLW'(pkts)};
  endfunction

  function automatic logic [FLIT_SIZE-1:0] data_flit(input logic [1:0] ftype,
                                                     input logic [PLD_W-1:0] pld);
    return {ftype, pld};
  endfunction

  // State register and all datapath flops; reset returns everything to idle values
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      budget_q    <= '0;
      pkt_cnt_q   <= '0;
      flit_cnt_q  <= '0;
      flit_idx_q  <= '0;
      dest_ptr_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      stop_seen_q <= 1'b0;
      flit_q      <= '0;
      transmit_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      budget_q    <= budget_d;
      pkt_cnt_q   <= pkt_cnt_d;
      flit_cnt_q  <= flit_cnt_d;
      flit_idx_q  <= flit_idx_d;
      dest_ptr_q  <= dest_ptr_d;
      lfsr_q      <= lfsr_d;
      stop_seen_q <= stop_seen_d;
      flit_q      <= flit_d;
      transmit_q  <= transmit_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-flit computation
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    budget_d    = budget_q;
    pkt_cnt_d   = pkt_cnt_q;
    flit_cnt_d  = flit_cnt_q;
    flit_idx_d  = flit_idx_q;
    dest_ptr_d  = dest_ptr_q;
    lfsr_d      = lfsr_q;
    stop_seen_d = stop_seen_q;
    flit_d      = flit_q;
    transmit_d  = 1'b0;
    done_d      = done_q;

    is_tail     = (flit_idx_q == LAST_IDX);
    pkt_cnt_inc = pkt_cnt_q + 1'b1;
    case (mode_q)
      2'd1:    dest = dest_ptr_q;
      2'd2:    dest = ADDR_W'(32'(lfsr_q[ADDR_W-1:0]) % NUM_DEST);
      default: dest = '0;
    endcase
    payload = (mode_q == 2'd2) ? PLD_W'(lfsr_q) : PLD_W'(flit_cnt_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d     = S_SEND;
          mode_d      = i_mode;
          gap_d       = i_gap;
          budget_d    = i_num_pkts;
          pkt_cnt_d   = '0;
          flit_cnt_d  = '0;
          flit_idx_d  = '0;
          dest_ptr_d  = '0;
          lfsr_d      = LFSR_SEED;
          stop_seen_d = 1'b0;
          done_d      = 1'b0;
        end
      end
      S_SEND: begin
        if (i_stop) stop_seen_d = 1'b1;
        if (i_on_off) begin
          transmit_d = 1'b1;
          flit_cnt_d = flit_cnt_q + 1'b1;
          if (mode_q == 2'd2) lfsr_d = lfsr_next(lfsr_q);
          if (flit_idx_q == '0)
            flit_d = head_flit(dest, pkt_cnt_q);
          else if (is_tail)
            flit_d = data_flit(2'b10, payload);
          else
            flit_d = data_flit(2'b00, payload);
          if (is_tail) begin
            flit_idx_d  = '0;
            pkt_cnt_d   = pkt_cnt_inc;
            stop_seen_d = 1'b0;
            dest_ptr_d  = (dest_ptr_q == LAST_DEST) ? '0 : dest_ptr_q + 1'b1;
            // Budget completion outranks a pending stop
            if (budget_q != '0 && pkt_cnt_inc == budget_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (stop_seen_q || i_stop) begin
              state_d = S_IDLE;
            end else if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            flit_idx_d = flit_idx_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (i_stop)
          state_d = S_IDLE;
        else if (gap_cnt_q == GAP_W'(1))
          state_d = S_SEND;
        else
          gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_busy     = (state_q == S_SEND) || (state_q == S_GAP);
    o_flit     = flit_q;
    o_transmit = transmit_q;
    o_done     = done_q;
    o_pkt_cnt  = pkt_cnt_q;
    o_flit_cnt = flit_cnt_q;
  end

endmodule

// File: tb/tb_packet_traffic_gen.sv
// tb_packet_traffic_gen: directed scoreboard bench for packet_traffic_gen
// with default parameters (32-bit flits, 4-flit packets, 4 destinations).
module tb_packet_traffic_gen;
  logic        clk = 1'b0;
  logic        reset, i_start, i_stop, i_on_off;
  logic [1:0]  i_mode;
  logic [7:0]  i_gap;
  logic [15:0] i_num_pkts;
  logic [31:0] o_flit;
  logic        o_transmit, o_busy, o_done;
  logic [15:0] o_pkt_cnt, o_flit_cnt;

  packet_traffic_gen dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_gap(i_gap), .i_num_pkts(i_num_pkts), .i_on_off(i_on_off),
    .o_flit(o_flit), .o_transmit(o_transmit), .o_busy(o_busy), .o_done(o_done),
    .o_pkt_cnt(o_pkt_cnt), .o_flit_cnt(o_flit_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  logic [31:0] run1_q[$];
  int gaps_q[$];
  int tx_total, first_tx, last_tx, idle_since_tail;
  bit seen_tail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | ({15'd0, fb} << 15);
  endfunction

  // Push the full expected flit stream of a fresh run of npkts packets.
  task automatic expect_run(input int mode, input int npkts);
    logic [15:0] l;
    logic [1:0]  d;
    logic [29:0] pld;
    int fc;
    l = 16'hACE1;
    fc = 0;
    for (int p = 0; p < npkts; p++) begin
      for (int f = 0; f < 4; f++) begin
        pld = (mode == 2) ? {14'd0, l} : 30'(fc);
        if (f == 0) begin
          d = (mode == 1) ? 2'(p % 4) : (mode == 2) ? l[1:0] : 2'd0;
          exp_q.push_back({2'b01, d, 28'(p)});
        end else begin
          exp_q.push_back({(f == 3) ? 2'b10 : 2'b00, pld});
        end
        if (mode == 2) l = lfsr_step(l);
        fc++;
      end
    end
  endtask

  task automatic clear_stats();
    tx_total = 0; first_tx = -1; last_tx = -1; idle_since_tail = 0;
    seen_tail = 1'b0;
    gaps_q.delete();
    log_q.delete();
  endtask

  // One clock: sample #1 after the edge, score any emitted flit.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (o_transmit) begin
      log_q.push_back(o_flit);
      tx_total++;
      if (first_tx < 0) first_tx = cyc;
      last_tx = cyc;
      if (exp_q.size() == 0) begin
        check("extra_flit", 64'(o_transmit), 64'(0));
      end else begin
        check("flit", 64'(o_flit), 64'(exp_q.pop_front()));
      end
      if (o_flit[31:30] == 2'b01 && seen_tail) gaps_q.push_back(idle_since_tail);
      if (o_flit[31:30] == 2'b10) begin
        seen_tail = 1'b1;
        idle_since_tail = 0;
      end
    end else if (seen_tail) begin
      idle_since_tail++;
    end
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [7:0] gap,
                           input logic [15:0] budget);
    i_mode = mode; i_gap = gap; i_num_pkts = budget;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic run_to_end(input int max_cycles);
    int n;
    n = 0;
    while (o_busy && n < max_cycles) begin
      tick();
      n++;
    end
    if (o_busy) check("timeout_busy", 64'(o_busy), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flit"}, 64'(o_flit), 64'(0));
    check({tag, "_transmit"}, 64'(o_transmit), 64'(0));
    check({tag, "_busy"}, 64'(o_busy), 64'(0));
    check({tag, "_done"}, 64'(o_done), 64'(0));
    check({tag, "_pkt_cnt"}, 64'(o_pkt_cnt), 64'(0));
    check({tag, "_flit_cnt"}, 64'(o_flit_cnt), 64'(0));
  endtask

  int start_cyc;

  initial begin
    reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_on_off = 1'b1;
    i_mode = 2'd0; i_gap = 8'd0; i_num_pkts = 16'd0;
    clear_stats();
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Budget run, mode 0, 3 packets back to back
    clear_stats();
    expect_run(0, 3);
    start_run(2'd0, 8'd0, 16'd3);
    start_cyc = cyc;
    check("busy_after_start", 64'(o_busy), 64'(1));
    run_to_end(100);
    check("budget_latency", 64'(first_tx - start_cyc), 64'(1));
    check("budget_tx_total", 64'(tx_total), 64'(12));
    check("budget_span", 64'(last_tx - first_tx + 1), 64'(12));
    foreach (gaps_q[i]) check("budget_gap", 64'(gaps_q[i]), 64'(0));
    check("budget_done", 64'(o_done), 64'(1));
    check("budget_pkt_cnt", 64'(o_pkt_cnt), 64'(3));
    check("budget_flit_cnt", 64'(o_flit_cnt), 64'(12));
    check("budget_queue_empty", 64'(exp_q.size()), 64'(0));

    // Round-robin with a 2-cycle gap, 5 packets
    clear_stats();
    expect_run(1, 5);
    start_run(2'd1, 8'd2, 16'd5);
    check("rr_done_cleared", 64'(o_done), 64'(0));
    run_to_end(200);
    check("rr_gap_count", 64'(gaps_q.size()), 64'(4));
    foreach (gaps_q[i]) check("rr_gap_len", 64'(gaps_q[i]), 64'(2));
    check("rr_pkt_cnt", 64'(o_pkt_cnt), 64'(5));
    check("rr_done", 64'(o_done), 64'(1));
    check("rr_queue_empty", 64'(exp_q.size()), 64'(0));

    // Backpressure: on sampled 1,0,0,1 after the head
    clear_stats();
    expect_run(0, 1);
    start_run(2'd0, 8'd0, 16'd1);
    tick();
    i_on_off = 1'b0;
    tick();
    check("bp_off1", 64'(o_transmit), 64'(0));
    tick();
    check("bp_off2", 64'(o_transmit), 64'(0));
    i_on_off = 1'b1;
    run_to_end(50);
    check("bp_tx_total", 64'(tx_total), 64'(4));
    check("bp_done", 64'(o_done), 64'(1));
    check("bp_flit_cnt", 64'(o_flit_cnt), 64'(4));
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Stop on the body flit, unbounded budget
    clear_stats();
    expect_run(0, 1);
    start_run(2'd0, 8'd0, 16'd0);
    tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    run_to_end(50);
    tick(); tick();
    check("stop_busy", 64'(o_busy), 64'(0));
    check("stop_done", 64'(o_done), 64'(0));
    check("stop_pkt_cnt", 64'(o_pkt_cnt), 64'(1));
    check("stop_tx_total", 64'(tx_total), 64'(4));
    check("stop_queue_empty", 64'(exp_q.size()), 64'(0));

    // LFSR mode, two identical runs
    clear_stats();
    expect_run(2, 2);
    start_run(2'd2, 8'd0, 16'd2);
    run_to_end(100);
    run1_q = log_q;
    check("lfsr_run1_len", 64'(run1_q.size()), 64'(8));
    if (run1_q.size() > 0) check("lfsr_first_dest", 64'(run1_q[0][29:28]), 64'(1));
    clear_stats();
    expect_run(2, 2);
    start_run(2'd2, 8'd0, 16'd2);
    run_to_end(100);
    check("lfsr_run2_len", 64'(log_q.size()), 64'(run1_q.size()));
    for (int i = 0; i < log_q.size() && i < run1_q.size(); i++)
      check("lfsr_repeat", 64'(log_q[i]), 64'(run1_q[i]));
    check("lfsr_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset after two flits, then a clean packet
    clear_stats();
    expect_run(0, 1);
    start_run(2'd0, 8'd0, 16'd0);
    tick(); tick();
    check("midrst_tx_before", 64'(tx_total), 64'(2));
    exp_q.delete();
    reset = 1'b1;
    tick();
    check_zero("midrst");
    reset = 1'b0;
    tick();
    check("midrst_quiet", 64'(o_transmit), 64'(0));
    clear_stats();
    expect_run(0, 1);
    start_run(2'd0, 8'd0, 16'd1);
    run_to_end(50);
    check("midrst_pkt_cnt", 64'(o_pkt_cnt), 64'(1));
    check("midrst_flit_cnt", 64'(o_flit_cnt), 64'(4));
    check("midrst_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/packet_traffic_gen.md
# packet_traffic_gen

Parametrised packet-level traffic source for NoC router benches and on-chip self-test. Emits complete head/body/tail packets of configurable length and destination pattern on a router input port and obeys the router's on/off backpressure. Gives run control (start/stop/packet budget), inter-packet gap and flit/packet counters that the single-mode TrafficGenerator does not have.

## Interface
- FLIT_SIZE, 32, flit width in bits; must be ≥ ADDR_W+4
- PKT_LEN, 4, flits per packet including head and tail; must be ≥ 2
- NUM_DEST, 4, number of destination ports; ADDR_W = $clog2(NUM_DEST), minimum 1
- GAP_W, 8, width of the inter-packet gap field
- CNT_W, 16, width of the packet budget and the counters
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- i_start  in  1  start a run; latches the config inputs and clears the counters
- i_stop  in  1  end the run after the current packet
- i_mode  in  2  0 fixed dest 0; 1 round-robin dest; 2 LFSR dest and payload; 3 behaves as 0
- i_gap  in  GAP_W  idle cycles inserted after each tail
- i_num_pkts  in  CNT_W  packet budget; 0 means unbounded
- i_on_off  in  1  downstream on/off; 1 means a flit may be sent
- o_flit  out  FLIT_SIZE  current flit
- o_transmit  out  1  o_flit is valid this cycle
- o_busy  out  1  a run is active (state SEND or GAP)
- o_done  out  1  packet budget reached; held until the next i_start
- o_pkt_cnt  out  CNT_W  tails sent this run
- o_flit_cnt  out  CNT_W  flits sent this run

## Operation
- States: IDLE, SEND, GAP, DONE. Reset puts the block in IDLE.
- IDLE or DONE, i_start=1: latch mode, gap and budget; clear both counters, flit index, dest pointer and o_done; seed the LFSR to 16'hACE1; go to SEND.
- SEND, at an edge with i_on_off=1: register the next flit and set o_transmit=1. At an edge with i_on_off=0: o_transmit=0 and o_flit holds its value.
- Flit type field is bits [FLIT_SIZE-1:FLIT_SIZE-2]:
  - head 01: bits [FLIT_SIZE-3 -: ADDR_W] carry dest; the remaining low bits carry o_pkt_cnt, truncated to fit.
  - body 00 and tail 10: bits [FLIT_SIZE-3:0] carry the payload.
- Payload: modes 0/1 use o_flit_cnt before increment, zero-extended or truncated. Mode 2 uses the LFSR, zero-extended.
- Dest pattern:
  - mode 0: always 0.
  - mode 1: 0,1,…,NUM_DEST-1 then wraps; advances per packet.
  - mode 2: LFSR[ADDR_W-1:0] modulo NUM_DEST.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. Advances once per emitted flit, mode 2 only.
- Tail emitted, budget reached (budget≠0 and o_pkt_cnt equals budget after increment): go to DONE, o_done=1.
- Tail emitted, i_stop seen since the head: go to IDLE.
- Tail emitted otherwise: go to GAP if i_gap≠0, else stay in SEND (next head may follow on the next edge).
- i_stop never truncates a packet. i_stop in GAP goes to IDLE at the next edge.
- GAP counts i_gap cycles with o_transmit=0, then returns to SEND.
- i_start while o_busy=1 is ignored.
- Counters wrap modulo 2^CNT_W. In DONE and IDLE the counters hold their values for readback.

## Timing
- Reset values: o_flit=0, o_transmit=0, o_busy=0, o_done=0, o_pkt_cnt=0, o_flit_cnt=0.
- Reset mid-packet: all outputs return to reset values after that edge; no tail is emitted.
- Reset has priority over every other input.
- i_start at edge N puts the block in SEND. The head is registered at edge N+1 if i_on_off=1 there, so 2 edges minimum from start to first flit.
- Each flit is registered at an edge and visible for exactly the following cycle.
- Back-to-back packets with i_gap=0 under constant on: one flit per cycle, no bubble.
- Gap: with i_gap=G, exactly G cycles with o_transmit=0 separate the tail and the next head (on held high).
- o_pkt_cnt and o_done update at the same edge that registers the tail. o_flit_cnt updates at each emitting edge.
- i_on_off dropping mid-packet stalls the packet without reordering. The flit index resumes where it stopped.

## Test plan
- Budget run: mode 0, PKT_LEN=4, i_num_pkts=3, i_gap=0, on held at 1 -> 12 consecutive o_transmit cycles; types 01,00,00,10 repeating; dest 0; o_done=1 with o_pkt_cnt=3, o_flit_cnt=12.
- Round-robin with gap: mode 1, NUM_DEST=4, i_gap=2, i_num_pkts=5 -> head dest 0,1,2,3,0; exactly 2 idle cycles between each tail and the next head.
- Backpressure: toggle i_on_off 1,0,0,1 during a packet -> no flit in the off-sampled cycles; payloads contiguous 0,1,2,3; tail still emitted.
- Stop: i_stop asserted on the body flit, unbounded budget -> packet completes with its tail, state IDLE, o_busy=0, o_done=0, o_pkt_cnt=1.
- LFSR determinism: mode 2, two runs each started with i_start -> identical flit sequences; first head dest = 16'hACE1[1:0] = 1.
- Reset mid-packet after 2 flits -> all outputs 0 after the next edge; a new i_start reproduces a clean packet from the head, counters starting at 0.
